// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU control unit:
// opcodes, sequencer states, write-source / ALU selects and instruction field positions.
package cpu_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int DATA_W_DEF = 16;
    localparam int RF_AW_DEF  = 4;
    localparam int DM_AW_DEF  = 8;

    // Instruction word layout: op[15:12] ra[11:8] rb[7:4] rd[3:0], imm8 overlaps rb/rd.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_ADD   = 4'd3,
        OP_LOADC = 4'd4,
        OP_SUB   = 4'd5,
        OP_JZ    = 4'd6,
        OP_HALT  = 4'd7
    } opcode_e;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        FETCH_W,
        DECODE,
        EXEC_LOADC,
        EXEC_ALU,
        EXEC_STORE,
        LD_REQ,
        LD_WB,
        EXEC_JZ,
        HALT
    } state_e;

    localparam logic [1:0] WS_ALU   = 2'd0;
    localparam logic [1:0] WS_DMEM  = 2'd1;
    localparam logic [1:0] WS_CONST = 2'd2;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef struct packed {
        opcode_e    op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rd;
        logic [7:0] imm8;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus between the sequencer and its surroundings: instruction ROM, data memory,
// register file and ALU controls, plus the run level and status flags.
interface cpu_sequencer_if
    import cpu_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RF_AW  = RF_AW_DEF,
    parameter int DM_AW  = DM_AW_DEF
);

    logic              run;
    logic [PC_W-1:0]   imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DM_AW-1:0]  dmem_addr;
    logic              dmem_rd;
    logic              dmem_wr;
    logic [RF_AW-1:0]  rf_rd_a_addr;
    logic [RF_AW-1:0]  rf_rd_b_addr;
    logic              rf_a_zero;
    logic              rf_wr;
    logic [RF_AW-1:0]  rf_wr_addr;
    logic [1:0]        rf_wr_sel;
    logic [DATA_W-1:0] rf_const;
    logic              alu_sel;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              halted;
    logic              illegal;

    modport master (
        input  run, imem_data, rf_a_zero,
        output imem_addr, dmem_addr, dmem_rd, dmem_wr,
               rf_rd_a_addr, rf_rd_b_addr, rf_wr, rf_wr_addr, rf_wr_sel, rf_const,
               alu_sel, pc, busy, halted, illegal
    );

    modport slave (
        output run, imem_data, rf_a_zero,
        input  imem_addr, dmem_addr, dmem_rd, dmem_wr,
               rf_rd_a_addr, rf_rd_b_addr, rf_wr, rf_wr_addr, rf_wr_sel, rf_const,
               alu_sel, pc, busy, halted, illegal
    );

endinterface

// File: rtl/instr_decode.sv
// Combinational instruction field extraction; undefined opcodes (8-15) are
// flagged illegal and reported as NOOP so the sequencer treats them alike.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] i_ir,
    output dec_t        o_dec
);

    always_comb begin
        o_dec.ra      = i_ir[RA_MSB:RA_LSB];
        o_dec.rb      = i_ir[RB_MSB:RB_LSB];
        o_dec.rd      = i_ir[RD_MSB:RD_LSB];
        o_dec.imm8    = i_ir[IMM_MSB:IMM_LSB];
        o_dec.illegal = i_ir[OP_MSB];
        o_dec.op      = i_ir[OP_MSB] ? OP_NOOP : opcode_e'(i_ir[OP_MSB:OP_LSB]);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU. Owns PC and IR;
// every output is a Moore decode of the state and IR registers.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RF_AW  = RF_AW_DEF,
    parameter int DM_AW  = DM_AW_DEF
) (
    input logic             clk,
    input logic             rst_n,
    cpu_sequencer_if.master bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    state_e            w_boundary;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [PC_W-1:0]   w_pc_off;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] w_ir_nxt;
    dec_t              w_dec;

    instr_decode u_decode (
        .i_ir  (r_ir[15:0]),
        .o_dec (w_dec)
    );

    assign w_pc_off   = PC_W'($signed(w_dec.imm8));
    assign w_boundary = bus.run ? FETCH : IDLE;

    // NOTE: sequential state uses non-blocking assignments only; the async
    // reset clears state, PC and IR so every decoded output drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        case (r_state)
            IDLE:    if (bus.run) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = FETCH_W;
            FETCH_W: begin
                w_ir_nxt    = bus.imem_data;
                w_pc_nxt    = r_pc + PC_W'(1);
                w_state_nxt = DECODE;
            end
            DECODE: begin
                case (w_dec.op)
                    OP_LOAD:         w_state_nxt = LD_REQ;
                    OP_STORE:        w_state_nxt = EXEC_STORE;
                    OP_ADD, OP_SUB:  w_state_nxt = EXEC_ALU;
                    OP_LOADC:        w_state_nxt = EXEC_LOADC;
                    OP_JZ:           w_state_nxt = EXEC_JZ;
                    OP_HALT:         w_state_nxt = HALT;
                    default:         w_state_nxt = w_boundary;
                endcase
            end
            // Branch offset is relative to the PC already advanced in FETCH_W.
            EXEC_JZ: begin
                if (bus.rf_a_zero) w_pc_nxt = r_pc + w_pc_off;
                w_state_nxt = w_boundary;
            end
            LD_REQ:  w_state_nxt = LD_WB;
            EXEC_LOADC, EXEC_ALU, EXEC_STORE, LD_WB: w_state_nxt = w_boundary;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: every output is given a default before the case so no latch is inferred.
    always_comb begin
        bus.imem_addr    = '0;
        bus.dmem_addr    = '0;
        bus.dmem_rd      = 1'b0;
        bus.dmem_wr      = 1'b0;
        bus.rf_rd_a_addr = '0;
        bus.rf_rd_b_addr = '0;
        bus.rf_wr        = 1'b0;
        bus.rf_wr_addr   = '0;
        bus.rf_wr_sel    = WS_ALU;
        bus.rf_const     = '0;
        bus.alu_sel      = ALU_ADD;
        bus.illegal      = 1'b0;
        bus.pc           = r_pc;
        bus.busy         = (r_state != IDLE) && (r_state != HALT);
        bus.halted       = (r_state == HALT);
        case (r_state)
            FETCH:  bus.imem_addr = r_pc;
            DECODE: bus.illegal   = w_dec.illegal;
            EXEC_LOADC: begin
                bus.rf_wr      = 1'b1;
                bus.rf_wr_sel  = WS_CONST;
                bus.rf_wr_addr = RF_AW'(w_dec.ra);
                bus.rf_const   = DATA_W'($signed(w_dec.imm8));
            end
            EXEC_ALU: begin
                bus.rf_rd_a_addr = RF_AW'(w_dec.ra);
                bus.rf_rd_b_addr = RF_AW'(w_dec.rb);
                bus.alu_sel      = (w_dec.op == OP_SUB) ? ALU_SUB : ALU_ADD;
                bus.rf_wr        = 1'b1;
                bus.rf_wr_sel    = WS_ALU;
                bus.rf_wr_addr   = RF_AW'(w_dec.rd);
            end
            EXEC_STORE: begin
                bus.rf_rd_a_addr = RF_AW'(w_dec.ra);
                bus.dmem_addr    = DM_AW'(w_dec.imm8);
                bus.dmem_wr      = 1'b1;
            end
            LD_REQ: begin
                bus.dmem_addr = DM_AW'(w_dec.imm8);
                bus.dmem_rd   = 1'b1;
            end
            // Address stays up while the returned data is written back.
            LD_WB: begin
                bus.dmem_addr  = DM_AW'(w_dec.imm8);
                bus.rf_wr      = 1'b1;
                bus.rf_wr_sel  = WS_DMEM;
                bus.rf_wr_addr = RF_AW'(w_dec.ra);
            end
            EXEC_JZ: bus.rf_rd_a_addr = RF_AW'(w_dec.ra);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: single-instruction vector table, directed multi-cycle
// sequences, and random programs compared against an instruction-level model.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous instruction ROM
    logic [15:0] rom [256];
    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    // Datapath environment: register file, data memory, ALU, follows the strobes
    logic [15:0] rf_m [16];
    logic [15:0] dm_m [256];
    logic [15:0] rf_init [16];
    logic [15:0] dm_init [256];
    logic [15:0] dm_q;
    logic        dp_load  = 1'b0;
    logic        az_force = 1'b0;
    logic        az_val   = 1'b0;

    assign bus.rf_a_zero = az_force ? az_val : (rf_m[bus.rf_rd_a_addr] == 16'h0000);

    always @(posedge clk) begin
        if (dp_load) begin
            for (int i = 0; i < 16; i++) rf_m[i] <= rf_init[i];
            for (int i = 0; i < 256; i++) dm_m[i] <= dm_init[i];
        end else begin
            if (bus.dmem_rd) dm_q <= dm_m[bus.dmem_addr];
            if (bus.dmem_wr) dm_m[bus.dmem_addr] <= rf_m[bus.rf_rd_a_addr];
            if (bus.rf_wr) begin
                case (bus.rf_wr_sel)
                    WS_ALU:   rf_m[bus.rf_wr_addr] <= bus.alu_sel ? rf_m[bus.rf_rd_a_addr] - rf_m[bus.rf_rd_b_addr]
                                                                  : rf_m[bus.rf_rd_a_addr] + rf_m[bus.rf_rd_b_addr];
                    WS_DMEM:  rf_m[bus.rf_wr_addr] <= dm_q;
                    WS_CONST: rf_m[bus.rf_wr_addr] <= bus.rf_const;
                    default:  rf_m[bus.rf_wr_addr] <= 16'hDEAD;
                endcase
            end
        end
    end

    // At most one of the three strobes may be high in any cycle
    always @(negedge clk) begin
        if (rst_n) check("strobe_onehot", 64'(($countones({bus.rf_wr, bus.dmem_wr, bus.dmem_rd}) > 1)), 64'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [41:0] exec_snap();
        return {bus.rf_wr, bus.rf_wr_addr, bus.rf_wr_sel, bus.rf_const, bus.rf_rd_a_addr,
                bus.rf_rd_b_addr, bus.alu_sel, bus.dmem_wr, bus.dmem_rd, bus.dmem_addr};
    endfunction

    function automatic logic [41:0] mk_snap(input logic wr, input logic [3:0] wa, input logic [1:0] ws,
                                            input logic [15:0] k, input logic [3:0] a, input logic [3:0] b,
                                            input logic alu, input logic dw, input logic dr, input logic [7:0] da);
        return {wr, wa, ws, k, a, b, alu, dw, dr, da};
    endfunction

    function automatic logic [60:0] all_outs();
        return {bus.imem_addr, bus.dmem_addr, bus.dmem_rd, bus.dmem_wr, bus.rf_rd_a_addr, bus.rf_rd_b_addr,
                bus.rf_wr, bus.rf_wr_addr, bus.rf_wr_sel, bus.rf_const, bus.alu_sel, bus.pc, bus.busy,
                bus.halted, bus.illegal};
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.run  = 1'b0;
        az_force = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic dp_init();
        dp_load = 1'b1;
        @(negedge clk);
        dp_load = 1'b0;
    endtask

    // Instruction-level reference: architectural effect and cycle cost per instruction
    logic [15:0] ref_rf [16];
    logic [15:0] ref_dm [256];
    logic [7:0]  ref_pc;
    int          ref_cycles;

    task automatic ref_run();
        logic [15:0] ins;
        logic [7:0]  p;
        bit          done;
        p          = 8'h00;
        ref_cycles = 1;
        done       = 1'b0;
        for (int s = 0; s < 3000 && !done; s++) begin
            ins = rom[p];
            p   = p + 8'd1;
            case (ins[15:12])
                4'h1: begin ref_rf[ins[11:8]] = ref_dm[ins[7:0]]; ref_cycles += 5; end
                4'h2: begin ref_dm[ins[7:0]] = ref_rf[ins[11:8]]; ref_cycles += 4; end
                4'h3: begin ref_rf[ins[3:0]] = ref_rf[ins[11:8]] + ref_rf[ins[7:4]]; ref_cycles += 4; end
                4'h4: begin ref_rf[ins[11:8]] = {{8{ins[7]}}, ins[7:0]}; ref_cycles += 4; end
                4'h5: begin ref_rf[ins[3:0]] = ref_rf[ins[11:8]] - ref_rf[ins[7:4]]; ref_cycles += 4; end
                4'h6: begin
                    if (ref_rf[ins[11:8]] == 16'h0000) p = p + ins[7:0];
                    ref_cycles += 4;
                end
                4'h7: begin ref_cycles += 3; done = 1'b1; end
                default: ref_cycles += 3;
            endcase
        end
        ref_pc = p;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] a = 4'($urandom_range(0, 15));
        logic [3:0] b = 4'($urandom_range(0, 15));
        logic [3:0] d = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
            0:       return {4'h0, 12'($urandom)};
            1:       return {4'h1, a, 4'h0, d};
            2:       return {4'h2, a, 4'h0, d};
            3, 8:    return {4'h3, a, b, d};
            4:       return {4'h4, a, 8'($urandom)};
            5, 9:    return {4'h5, a, b, d};
            6:       return {4'h6, a, 8'($urandom_range(0, 4))};
            default: return {4'($urandom_range(8, 15)), 12'($urandom)};
        endcase
    endfunction

    typedef struct {
        logic [15:0] instr;
        logic        az;
        int          busy_cyc;
        logic [7:0]  pc_after;
        int          ill_cyc;
        logic        halt;
        logic [41:0] snap;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          busy_n, ill_n, add_c, sub_c, wr_c, rd_c, cyc;
        bit          found;
        logic [41:0] snap_act;
        logic [7:0]  jpc;

        // Fourth cycle after run is sampled: exec cycle (LD_REQ for LOAD, IDLE after NOOP/illegal/HALT)
        vecs[0]  = '{16'h4105, 1'b0, 4, 8'h01, 0, 1'b0, mk_snap(1, 4'h1, WS_CONST, 16'h0005, 0, 0, 0, 0, 0, 8'h00)};
        vecs[1]  = '{16'h42FF, 1'b0, 4, 8'h01, 0, 1'b0, mk_snap(1, 4'h2, WS_CONST, 16'hFFFF, 0, 0, 0, 0, 0, 8'h00)};
        vecs[2]  = '{16'h3123, 1'b0, 4, 8'h01, 0, 1'b0, mk_snap(1, 4'h3, WS_ALU, 16'h0000, 4'h1, 4'h2, 0, 0, 0, 8'h00)};
        vecs[3]  = '{16'h5123, 1'b0, 4, 8'h01, 0, 1'b0, mk_snap(1, 4'h3, WS_ALU, 16'h0000, 4'h1, 4'h2, 1, 0, 0, 8'h00)};
        vecs[4]  = '{16'h2310, 1'b0, 4, 8'h01, 0, 1'b0, mk_snap(0, 4'h0, WS_ALU, 16'h0000, 4'h3, 4'h0, 0, 1, 0, 8'h10)};
        vecs[5]  = '{16'h1410, 1'b0, 5, 8'h01, 0, 1'b0, mk_snap(0, 4'h0, WS_ALU, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 8'h10)};
        vecs[6]  = '{16'h61FB, 1'b1, 4, 8'hFC, 0, 1'b0, mk_snap(0, 4'h0, WS_ALU, 16'h0000, 4'h1, 4'h0, 0, 0, 0, 8'h00)};
        vecs[7]  = '{16'h61FB, 1'b0, 4, 8'h01, 0, 1'b0, mk_snap(0, 4'h0, WS_ALU, 16'h0000, 4'h1, 4'h0, 0, 0, 0, 8'h00)};
        vecs[8]  = '{16'h0000, 1'b0, 3, 8'h01, 0, 1'b0, '0};
        vecs[9]  = '{16'h9000, 1'b0, 3, 8'h01, 1, 1'b0, '0};
        vecs[10] = '{16'hF123, 1'b0, 3, 8'h01, 1, 1'b0, '0};
        vecs[11] = '{16'h7000, 1'b0, 3, 8'h01, 0, 1'b1, '0};

        for (int i = 0; i < 16; i++) rf_init[i] = '0;
        for (int i = 0; i < 256; i++) dm_init[i] = '0;
        fill_rom(16'h0000);
        do_reset();
        dp_init();
        check("reset_outputs", 64'(all_outs()), 64'd0);

        // ---- table of single instructions, run released after the first fetch ----
        for (int v = 0; v < 12; v++) begin
            do_reset();
            fill_rom(16'h0000);
            rom[0]   = vecs[v].instr;
            az_force = 1'b1;
            az_val   = vecs[v].az;
            bus.run  = 1'b1;
            busy_n   = 0;
            ill_n    = 0;
            snap_act = '0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c == 1) bus.run = 1'b0;
                if (bus.busy) busy_n++;
                if (bus.illegal) ill_n++;
                if (c == 4) snap_act = exec_snap();
            end
            check($sformatf("vec%0d_exec", v), 64'(snap_act), 64'(vecs[v].snap));
            check($sformatf("vec%0d_busy_cycles", v), 64'(busy_n), 64'(vecs[v].busy_cyc));
            check($sformatf("vec%0d_pc", v), 64'(bus.pc), 64'(vecs[v].pc_after));
            check($sformatf("vec%0d_illegal_cycles", v), 64'(ill_n), 64'(vecs[v].ill_cyc));
            check($sformatf("vec%0d_halted", v), 64'(bus.halted), 64'(vecs[v].halt));
        end

        // ---- async reset in the middle of an ADD write ----
        do_reset();
        fill_rom(16'h7000);
        rom[0]  = 16'h3123;
        bus.run = 1'b1;
        found   = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus.rf_wr) found = 1'b1;
        end
        check("midrun_write_seen", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", 64'(all_outs()), 64'd0);
        bus.run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_release", 64'(all_outs()), 64'd0);

        // ---- ADD then SUB spacing ----
        do_reset();
        fill_rom(16'h7000);
        rom[0]  = 16'h3123;
        rom[1]  = 16'h5123;
        bus.run = 1'b1;
        add_c   = -1;
        sub_c   = -1;
        for (int c = 1; c <= 30 && !bus.halted; c++) begin
            @(negedge clk);
            if (bus.rf_wr && bus.rf_wr_sel == WS_ALU) begin
                if (bus.alu_sel == ALU_ADD) add_c = c;
                else sub_c = c;
                check($sformatf("alu_ports_c%0d", c), 64'({bus.rf_rd_a_addr, bus.rf_rd_b_addr, bus.rf_wr_addr}), 64'h123);
            end
        end
        check("add_cycle", 64'(add_c), 64'd4);
        check("sub_minus_add", 64'(sub_c - add_c), 64'd4);

        // ---- STORE then LOAD through address 0x10 ----
        do_reset();
        fill_rom(16'h7000);
        rom[0]     = 16'h2310;
        rom[1]     = 16'h1410;
        rf_init[3] = 16'hBEEF;
        dp_init();
        rf_init[3] = 16'h0000;
        bus.run    = 1'b1;
        wr_c       = -1;
        rd_c       = -1;
        for (int c = 1; c <= 30 && !bus.halted; c++) begin
            @(negedge clk);
            if (bus.dmem_wr) begin
                wr_c = c;
                check("store_addr_rda", 64'({bus.dmem_addr, bus.rf_rd_a_addr}), 64'h103);
            end
            if (rd_c > 0 && c == rd_c + 1)
                check("load_wb", 64'({bus.rf_wr, bus.rf_wr_sel, bus.rf_wr_addr, bus.dmem_addr}), 64'({1'b1, WS_DMEM, 4'h4, 8'h10}));
            if (bus.dmem_rd) begin
                rd_c = c;
                check("load_req_addr", 64'(bus.dmem_addr), 64'h10);
            end
        end
        check("store_cycle", 64'(wr_c), 64'd4);
        check("load_minus_store", 64'(rd_c - wr_c), 64'd4);
        check("load_roundtrip_r4", 64'(rf_m[4]), 64'hBEEF);

        // ---- JZ taken / not taken, and taken across the PC wrap ----
        for (int t = 0; t < 3; t++) begin
            do_reset();
            fill_rom(16'h0000);
            if (t < 2) rom[5] = 16'h61FB;
            else rom[255] = 16'h6102;
            dp_init();
            az_force = 1'b1;
            az_val   = (t != 1);
            bus.run  = 1'b1;
            found    = 1'b0;
            jpc      = (t < 2) ? 8'h05 : 8'hFF;
            jpc      = jpc + 8'd1;
            for (int c = 0; c < 1000 && !found; c++) begin
                @(negedge clk);
                if (bus.rf_rd_a_addr == 4'h1) begin
                    found = 1'b1;
                    check($sformatf("jz%0d_pc_in_exec", t), 64'(bus.pc), 64'(jpc));
                    @(negedge clk);
                    if (t == 0) jpc = jpc - 8'd5;
                    if (t == 2) jpc = jpc + 8'd2;
                    check($sformatf("jz%0d_next_fetch", t), 64'(bus.imem_addr), 64'(jpc));
                end
            end
            check($sformatf("jz%0d_reached", t), 64'(found), 64'd1);
        end

        // ---- pause during ADD, then resume ----
        do_reset();
        fill_rom(16'h7000);
        rom[0]  = 16'h3123;
        rom[1]  = 16'h5123;
        bus.run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        add_c   = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rf_wr && bus.alu_sel == ALU_ADD) add_c++;
        end
        check("pause_add_completed", 64'(add_c), 64'd1);
        check("pause_idle_pc", 64'({bus.busy, bus.pc}), 64'h001);
        repeat (4) @(negedge clk);
        check("pause_held_pc", 64'({bus.busy, bus.pc}), 64'h001);
        bus.run = 1'b1;
        @(negedge clk);
        check("resume_fetch_addr", 64'({bus.busy, bus.imem_addr}), 64'h101);
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk);
            if (bus.rf_wr) begin
                found = 1'b1;
                check("resume_sub", 64'({bus.alu_sel, bus.rf_wr_addr}), 64'h13);
            end
        end
        check("resume_reached_exec", 64'(found), 64'd1);

        // ---- HALT is sticky with run toggling ----
        do_reset();
        fill_rom(16'h0000);
        rom[0]  = 16'h7000;
        bus.run = 1'b1;
        for (int c = 0; c < 10 && !bus.halted; c++) @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            bus.run = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("halt_sticky_c%0d", c), 64'({bus.halted, bus.busy, bus.pc}), 64'h201);
        end
        rst_n = 1'b0;
        #1 check("halt_cleared_by_reset", 64'(bus.halted), 64'd0);

        // ---- random programs vs instruction-level model ----
        for (int p = 0; p < 6; p++) begin
            do_reset();
            fill_rom(16'h7000);
            for (int i = 0; i < 40; i++) rom[i] = rand_instr();
            for (int i = 0; i < 16; i++) begin
                rf_init[i] = 16'($urandom_range(0, 3));
                ref_rf[i]  = rf_init[i];
            end
            for (int i = 0; i < 256; i++) begin
                dm_init[i] = 16'($urandom_range(0, 3));
                ref_dm[i]  = dm_init[i];
            end
            dp_init();
            ref_run();
            bus.run = 1'b1;
            cyc     = 0;
            while (!bus.halted && cyc < ref_cycles + 50) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("rand%0d_halted", p), 64'(bus.halted), 64'd1);
            check($sformatf("rand%0d_cycles", p), 64'(cyc), 64'(ref_cycles));
            check($sformatf("rand%0d_pc", p), 64'(bus.pc), 64'(ref_pc));
            for (int i = 0; i < 16; i++) begin
                check($sformatf("rand%0d_r%0d", p, i), 64'(rf_m[i]), 64'(ref_rf[i]));
                check($sformatf("rand%0d_dm%0d", p, i), 64'(dm_m[i]), 64'(ref_dm[i]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
